// File: rtl/bsg_fifo_ctrl_pkg.sv
// Shared definitions for the small 1R1W FIFO controller: pointer sizing,
// the occupancy count type and the message text used by the optional
// simulation checks (enabled with BSG_FIFO_CTRL_CHECKS_EN).
package bsg_fifo_ctrl_pkg;

    // Pointer width: storage index bits plus one wrap bit.
    function automatic int ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

    localparam int OCC_W = 16;
    typedef logic [OCC_W-1:0] occ_t;

    localparam string ERR_UNDERFLOW = "bsg_fifo_1r1w_small_ctrl: yumi_i asserted while v_o is low";
    localparam string ERR_X_INPUT   = "bsg_fifo_1r1w_small_ctrl: v_i or yumi_i is X/Z out of reset";
    localparam string ERR_OVERFLOW  = "bsg_fifo_1r1w_small_ctrl: pointer occupancy exceeds els_p";

endpackage

// File: rtl/bsg_mem_1r1w_synth.sv
// Synthesized 1-write/1-read register-file memory. Writes are clocked,
// reads are combinational from the registered array. Contents are never
// reset; w_reset_i only blocks writes while reset is held.
module bsg_mem_1r1w_synth #(
    parameter int width_p                = 4,
    parameter int els_p                  = 2,
    parameter int read_write_same_addr_p = 0,
    parameter int harden_p               = 0,
    localparam int addr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     w_clk_i,
    input  logic                     w_reset_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // There is no hardened macro for this array; refuse to elaborate one.
    if (harden_p != 0) begin : g_no_hard_macro
        $error("bsg_mem_1r1w_synth: no hardened implementation available");
    end

    // Storage write port.
    always_ff @(posedge w_clk_i) begin
        if (w_v_i && !w_reset_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    // Read port; same-address write-through only when the caller allows it.
    always_comb begin
        r_data_o = '0;
        if (r_v_i) begin
            r_data_o = mem_r[r_addr_i];
            if ((read_write_same_addr_p != 0) && w_v_i && (w_addr_i == r_addr_i)) begin
                r_data_o = w_data_i;
            end
        end
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small_ctrl.sv
// Shallow ready/valid decoupling FIFO. Pointer and handshake logic live
// here; words are held in a bsg_mem_1r1w_synth instance. Pointers carry
// an extra wrap bit so full and empty are distinguished without a counter.
// Defining BSG_FIFO_CTRL_CHECKS_EN adds simulation-only protocol checks.
module bsg_fifo_1r1w_small_ctrl
    import bsg_fifo_ctrl_pkg::*;
#(
    parameter int width_p = 4,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int PTR_W = ptr_width(els_p);
    localparam int AW    = PTR_W - 1;

    logic [PTR_W-1:0] wptr_r, rptr_r;
    logic [PTR_W-1:0] wptr_d, rptr_d;
    logic             empty, full, enq, deq;

    assign empty   = (wptr_r == rptr_r);
    assign full    = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i;

    // Next-pointer computation; natural rollover gives modulo 2*els_p.
    always_comb begin
        wptr_d = wptr_r;
        rptr_d = rptr_r;
        if (enq) wptr_d = wptr_r + PTR_W'(1);
        if (deq) rptr_d = rptr_r + PTR_W'(1);
    end

    // Pointer registers, cleared immediately on reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            wptr_r <= wptr_d;
            rptr_r <= rptr_d;
        end
    end

    // Full blocks writes and empty blocks reads, so the two addresses never
    // collide on a consumed read; no write-through is needed.
    bsg_mem_1r1w_synth #(
        .width_p               (width_p),
        .els_p                 (els_p),
        .read_write_same_addr_p(0),
        .harden_p              (0)
    ) mem (
        .w_clk_i  (clk_i),
        .w_reset_i(~reset_n_i),
        .w_v_i    (enq),
        .w_addr_i (wptr_r[AW-1:0]),
        .w_data_i (data_i),
        .r_v_i    (v_o),
        .r_addr_i (rptr_r[AW-1:0]),
        .r_data_o (data_o)
    );

`ifdef BSG_FIFO_CTRL_CHECKS_EN
    occ_t occ;
    assign occ = occ_t'(PTR_W'(wptr_r - rptr_r));

    // Protocol and consistency checks sampled on every active edge.
    always_ff @(posedge clk_i) begin
        if (reset_n_i === 1'b1) begin
            if (yumi_i === 1'b1 && v_o === 1'b0) $error("%s", ERR_UNDERFLOW);
            if ($isunknown({v_i, yumi_i}))        $error("%s", ERR_X_INPUT);
            if (occ > occ_t'(els_p))              $error("%s", ERR_OVERFLOW);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_ctrl.sv
module tb_bsg_fifo_1r1w_small_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       v_i;
    logic [3:0] data_i;
    logic       ready_o;
    logic       v_o;
    logic [3:0] data_o;
    logic       yumi_i;

    int n_checks = 0;
    int n_fail   = 0;

    bsg_fifo_1r1w_small_ctrl #(.width_p(4), .els_p(2)) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (v_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .yumi_i   (yumi_i)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = 4'h0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ready_o !== 1'b1 || v_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d ready_o=%b v_o=%b required ready_o=1 v_o=0", i, ready_o, v_o);
            end
            tick();
        end
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (ready_o !== 1'b1 || v_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d ready_o=%b v_o=%b required ready_o=1 v_o=0", i, ready_o, v_o);
            end
        end
    endtask

    task automatic test_fill();
        v_i = 1'b1; data_i = 4'hA;
        tick();
        n_checks++;
        if (v_o !== 1'b1 || data_o !== 4'hA || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_first v_o=%b data_o=%h ready_o=%b required 1 a 1", v_o, data_o, ready_o);
        end
        data_i = 4'h5;
        tick();
        n_checks++;
        if (ready_o !== 1'b0 || v_o !== 1'b1 || data_o !== 4'hA) begin
            n_fail++;
            $display("FAIL fill_full ready_o=%b v_o=%b data_o=%h required 0 1 a", ready_o, v_o, data_o);
        end
        data_i = 4'hF;
        tick();
        n_checks++;
        if (ready_o !== 1'b0 || data_o !== 4'hA) begin
            n_fail++;
            $display("FAIL fill_reject ready_o=%b data_o=%h required 0 a", ready_o, data_o);
        end
        v_i = 1'b0;
    endtask

    task automatic test_drain();
        yumi_i = 1'b1;
        tick();
        n_checks++;
        if (v_o !== 1'b1 || data_o !== 4'h5 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_second v_o=%b data_o=%h ready_o=%b required 1 5 1", v_o, data_o, ready_o);
        end
        tick();
        yumi_i = 1'b0;
        n_checks++;
        if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty v_o=%b ready_o=%b required 0 1", v_o, ready_o);
        end
    endtask

    task automatic test_stream();
        v_i = 1'b1; data_i = 4'h0; yumi_i = 1'b0;
        n_checks++;
        if (v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_start v_o=%b required 0", v_o);
        end
        tick();
        for (int k = 1; k <= 10; k++) begin
            v_i    = (k <= 9);
            data_i = 4'(k);
            yumi_i = 1'b1;
            n_checks++;
            if (v_o !== 1'b1 || data_o !== 4'(k - 1) || ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_word k=%0d v_o=%b data_o=%h ready_o=%b required 1 %h 1",
                         k, v_o, data_o, ready_o, 4'(k - 1));
            end
            tick();
        end
        v_i = 1'b0; yumi_i = 1'b0;
        n_checks++;
        if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_end v_o=%b ready_o=%b required 0 1", v_o, ready_o);
        end
    endtask

    task automatic test_full_yumi_offer();
        v_i = 1'b1; data_i = 4'h1;
        tick();
        data_i = 4'h2;
        tick();
        data_i = 4'h3; yumi_i = 1'b1;
        n_checks++;
        if (ready_o !== 1'b0 || data_o !== 4'h1) begin
            n_fail++;
            $display("FAIL fyo_full ready_o=%b data_o=%h required 0 1", ready_o, data_o);
        end
        tick();
        yumi_i = 1'b0;
        n_checks++;
        if (v_o !== 1'b1 || data_o !== 4'h2 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fyo_after v_o=%b data_o=%h ready_o=%b required 1 2 1", v_o, data_o, ready_o);
        end
        tick();
        v_i = 1'b0;
        n_checks++;
        if (ready_o !== 1'b0 || data_o !== 4'h2) begin
            n_fail++;
            $display("FAIL fyo_accept ready_o=%b data_o=%h required 0 2", ready_o, data_o);
        end
        yumi_i = 1'b1;
        tick();
        n_checks++;
        if (v_o !== 1'b1 || data_o !== 4'h3) begin
            n_fail++;
            $display("FAIL fyo_third v_o=%b data_o=%h required 1 3", v_o, data_o);
        end
        tick();
        yumi_i = 1'b0;
        n_checks++;
        if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fyo_empty v_o=%b ready_o=%b required 0 1", v_o, ready_o);
        end
    endtask

    task automatic test_async_reset();
        v_i = 1'b1; data_i = 4'h7;
        tick();
        v_i = 1'b0;
        n_checks++;
        if (v_o !== 1'b1 || data_o !== 4'h7) begin
            n_fail++;
            $display("FAIL ares_hold v_o=%b data_o=%h required 1 7", v_o, data_o);
        end
        #2;
        reset_n_i = 1'b0;
        #1;
        n_checks++;
        if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ares_async v_o=%b ready_o=%b required 0 1", v_o, ready_o);
        end
        tick();
        reset_n_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (v_o !== 1'b0 || ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL ares_idle cyc=%0d v_o=%b ready_o=%b required 0 1", i, v_o, ready_o);
            end
        end
        v_i = 1'b1; data_i = 4'h9;
        tick();
        v_i = 1'b0; yumi_i = 1'b1;
        n_checks++;
        if (v_o !== 1'b1 || data_o !== 4'h9) begin
            n_fail++;
            $display("FAIL ares_new v_o=%b data_o=%h required 1 9", v_o, data_o);
        end
        tick();
        yumi_i = 1'b0;
        n_checks++;
        if (v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ares_no_stale v_o=%b data_o=%h required v_o=0", v_o, data_o);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_yumi_offer();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_fifo_1r1w_small_ctrl.md
# bsg_fifo_1r1w_small_ctrl

Small ready/valid FIFO that owns the producer and consumer sides of a 1-read/1-write synthesized register-file memory. It accepts words on a ready-then-valid input port, stores them in an internal `bsg_mem_1r1w_synth` instance, and presents the oldest word on a valid/yumi output port. Full/empty pointer arithmetic is kept outside the storage. The block is the standard shallow decoupling buffer between pipeline stages in the quad tile.

## Interface
- `width_p`, default 4: data word width in bits.
- `els_p`, default 2: number of entries; power of two, at least 2.
- `clk_i` in, 1 bit: single clock; all state updates on its rising edge.
- `reset_n_i` in, 1 bit: reset, asynchronous, active-low.
- `v_i` in, 1 bit: producer offers `data_i`.
- `data_i` in, `width_p` bits: word to enqueue.
- `ready_o` out, 1 bit: FIFO can accept a word this cycle.
- `v_o` out, 1 bit: `data_o` holds the oldest valid word.
- `data_o` out, `width_p` bits: head-of-queue word.
- `yumi_i` in, 1 bit: consumer takes the head word this cycle; legal only while `v_o`=1.

## Operation
- Pointers `wptr_r` and `rptr_r` are each `$clog2(els_p)`+1 bits wide. The low bits index storage; the MSB is the wrap bit.
- Empty when `wptr_r == rptr_r`. Full when the low bits are equal and the MSBs differ.
- `ready_o = ~full`. `v_o = ~empty`. Both are pure functions of registered pointers, with no combinational path from `v_i` or `yumi_i`.
- Enqueue is `enq = v_i & ready_o`. It drives the memory with `w_v_i = enq`, `w_addr_i = wptr_r[low]`, `w_data_i = data_i`. On enqueue, `wptr_r` increments modulo 2·els_p.
- Dequeue is `deq = yumi_i`. On dequeue, `rptr_r` increments modulo 2·els_p.
- Memory read: `r_v_i = v_o`, `r_addr_i = rptr_r[low]`, `data_o = r_data_o`, read combinationally from registered storage.
- Simultaneous enqueue and dequeue: both pointers advance and occupancy is unchanged.
  - When not full, this is always legal.
  - When full, `ready_o`=0, so only the dequeue happens. There is no same-cycle bypass of a freed slot.
  - When empty, `v_o`=0, so only the enqueue happens. There is no input-to-output bypass.
  - Read and write addresses therefore never collide in a cycle where the read data is consumed. This matches the memory's `read_write_same_addr_p`=0.
- Storage contents are not reset. `data_o` is don't-care while `v_o`=0.

## Timing
- Reset (`reset_n_i` low, asynchronous assertion) forces `wptr_r`=0 and `rptr_r`=0 immediately, regardless of clock. Outputs during and after reset: `ready_o`=1, `v_o`=0, `data_o` undefined.
- Reset asserted mid-operation discards all stored words. The first clock edge after deassertion may accept a write.
- Latency: a word accepted at edge N appears on `data_o` with `v_o`=1 immediately after edge N, i.e. one cycle.
- Throughput: one enqueue and one dequeue per cycle. Full bandwidth holds with `els_p`≥2 when the consumer always yumis.
- Wrap: pointers roll from 2·els_p−1 to 0. The full/empty decode stays correct across wrap.

## Configuration
- `BSG_FIFO_CTRL_CHECKS_EN` defined: simulation-only checks, each firing `$error` on the clock edge:
  - `yumi_i`=1 while `v_o`=0 (underflow);
  - `v_i` or `yumi_i` is X/Z while `reset_n_i`=1;
  - occupancy derived from the pointers exceeds `els_p`.
- `BSG_FIFO_CTRL_CHECKS_EN` undefined: no checks. Synthesized logic is identical in both cases.

## Structure
- Shared package `bsg_fifo_ctrl_pkg`:
  - function `ptr_width(els)` = `$clog2(els)`+1;
  - typedef for the occupancy count;
  - localparam error strings used by the checks.
- Sub-module: one instance of `bsg_mem_1r1w_synth` with `width_p`, `els_p`, `read_write_same_addr_p`=0 and `harden_p`=0. Its `w_reset_i` is tied to `~reset_n_i`.
- All pointer and handshake logic stays in this module; there is no further hierarchy.

## Test plan
- Reset then idle: hold `reset_n_i`=0 for 3 cycles, release → `ready_o`=1 and `v_o`=0 every cycle; `yumi_i` is never driven.
- Fill to full (`width_p`=4, `els_p`=2): enqueue 4'hA then 4'h5 with `yumi_i`=0 → after the 2nd edge `ready_o`=0; a 3rd offer of 4'hF is not accepted and `data_o`=4'hA.
- Drain in order: from the full state, `yumi_i`=1 for 2 cycles → `data_o` shows 4'hA, then 4'h5, then `v_o`=0 and `ready_o`=1.
- Streaming with wrap: `v_i`=`yumi_i`=1 every cycle over data 0..9 → outputs 0..9 in order with 1-cycle latency; pointers wrap at least twice with no loss or duplication.
- Full plus yumi with offer: full with 4'h1, 4'h2, then `v_i`=1 (4'h3) and `yumi_i`=1 together → 4'h1 is dequeued, 4'h3 is rejected that cycle, occupancy becomes 1; next cycle 4'h3 is accepted.
- Async reset mid-stream: assert `reset_n_i` between edges while holding 1 word → `v_o` drops before the next edge; after release the old word never appears.
